vec_mem_responder: RTL and testbench

//  Memory-side responder for the vector load/store path: services whole-vector requests from the LSQ

---
 rtl/vec_mem_responder.sv | 141 ++++++++++++++
 tb/tb_vec_mem_responder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/vec_mem_responder.sv
// vec_mem_responder
//   Memory-side responder for the vector load/store path. Serves whole-vector
//   requests against a banked, word-addressable data memory: one row (BANK_SIZE
//   32-bit lanes) moves per beat, and a vector is BEATS = VLEN/BANK_SIZE rows.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   request channel; req_we=1 store, 0 load; req_row = base row
//   wd_valid/wd_ready     store beat channel, wd_data lane k in bits [32k+31:32k]
//   rsp_valid/rsp_ready   load beat channel, rsp_data same packing, rsp_last on final beat
//   ack_valid             one-cycle pulse when a store completes
//   err                   range error for the current/last operation
//   dbg_state             current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. A valid source holds its payload stable until the transfer; ready may
// be driven independently of valid.
module vec_mem_responder #(
  parameter int BANK_SIZE = 8,
  parameter int DEPTH     = 120,
  parameter int VLEN      = 32,
  parameter int LATENCY   = 2,
  parameter int ROW_W     = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ROW_W-1:0]          req_row,
  input  logic                      wd_valid,
  output logic                      wd_ready,
  input  logic [32*BANK_SIZE-1:0]   wd_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [32*BANK_SIZE-1:0]   rsp_data,
  output logic                      rsp_last,
  output logic                      ack_valid,
  output logic                      err,
  output logic [2:0]                dbg_state
);

  localparam int BEATS  = VLEN / BANK_SIZE;
  localparam int DW     = 32 * BANK_SIZE;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LAT_W  = $clog2(LATENCY + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_WAIT = 3'd1,
    LD_RESP = 3'd2,
    ST_DATA = 3'd3,
    ST_ACK  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [ROW_W-1:0]  base;
  logic [BEAT_W-1:0] beat;
  logic [LAT_W-1:0]  lat_cnt;
  logic [DW-1:0]     mem [DEPTH];

  logic              req_fire, wd_fire, rsp_fire;
  logic              last_beat, lat_done, range_bad;
  logic [ROW_W:0]    end_row;
  logic [ROW_W-1:0]  addr;

  assign req_fire  = req_valid && req_ready;
  assign wd_fire   = wd_valid && wd_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign last_beat = (beat == BEAT_W'(BEATS - 1));
  // LD_WAIT lasts LATENCY-1 cycles, so data shows LATENCY cycles after acceptance.
  assign lat_done  = (int'(lat_cnt) >= LATENCY - 2);
  // One extra bit so a base near the top of memory cannot wrap past the check.
  assign end_row   = {1'b0, req_row} + (ROW_W + 1)'(BEATS - 1);
  assign range_bad = (end_row >= (ROW_W + 1)'(DEPTH));
  assign addr      = base + ROW_W'(beat);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_fire) begin
          if (req_we)            state_nxt = ST_DATA;
          else if (LATENCY == 1) state_nxt = LD_RESP;
          else                   state_nxt = LD_WAIT;
        end
      end
      LD_WAIT: if (lat_done)              state_nxt = LD_RESP;
      LD_RESP: if (rsp_fire && last_beat) state_nxt = IDLE;
      ST_DATA: if (wd_fire && last_beat)  state_nxt = ST_ACK;
      ST_ACK:                             state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  // Outputs. req_ready is gated by rst_n so it stays low while reset is held.
  always_comb begin
    req_ready = (state == IDLE) && rst_n;
    wd_ready  = (state == ST_DATA);
    rsp_valid = (state == LD_RESP);
    rsp_last  = (state == LD_RESP) && last_beat;
    ack_valid = (state == ST_ACK);
    rsp_data  = '0;
    if (state == LD_RESP && !err) rsp_data = mem[addr];
    dbg_state = state;
  end

  // Operation context: base row, beat index, latency count, error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base    <= '0;
      beat    <= '0;
      lat_cnt <= '0;
      err     <= 1'b0;
    end else begin
      if (req_fire) begin
        base    <= req_row;
        beat    <= '0;
        lat_cnt <= '0;
        err     <= range_bad;
      end
      if (state == LD_WAIT) lat_cnt <= lat_cnt + 1'b1;
      // Beat counter wraps to 0 after the final beat of each operation.
      if (rsp_fire || wd_fire) beat <= beat + 1'b1;
    end
  end

  // Data memory: not reset. Out-of-range stores are dropped.
  always_ff @(posedge clk) begin
    if (wd_fire && !err) mem[addr] <= wd_data;
  end

endmodule

// File: tb/tb_vec_mem_responder.sv
module tb_vec_mem_responder;

  localparam int DW = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          req_valid, req_ready, req_we;
  logic [6:0]    req_row;
  logic          wd_valid, wd_ready;
  logic [DW-1:0] wd_data;
  logic          rsp_valid, rsp_ready, rsp_last;
  logic [DW-1:0] rsp_data;
  logic          ack_valid, err;
  logic [2:0]    dbg_state;

  vec_mem_responder dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_row(req_row),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .ack_valid(ack_valid), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_bad    = 0;
  int ack_seen = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model [0:119];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (rst_n && ack_valid) ack_seen++;

  function automatic logic [DW-1:0] make_beat(input int base, input int b);
    logic [DW-1:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = 32'(base + 100*b + k);
    return v;
  endfunction

  // ---------------- driver tasks (entered and left at a negedge) ----------------
  task automatic send_req(input logic we, input logic [6:0] row);
    int w = 0;
    req_valid = 1'b1; req_we = we; req_row = row;
    while (!req_ready && w < 20) begin
      @(posedge clk); @(negedge clk); w++;
    end
    check("req_ready_idle", DW'(req_ready), DW'(1));
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic store_vec(input logic [6:0] row, input int base, input bit exp_err, input bit gaps);
    logic [DW-1:0] d;
    send_req(1'b1, row);
    for (int b = 0; b < 4; b++) begin
      if (gaps) begin
        wd_valid = 1'b0;
        check("st_gap_wd_ready", DW'(wd_ready), DW'(1));
        check("st_gap_req_ready", DW'(req_ready), DW'(0));
        check("st_gap_ack", DW'(ack_valid), DW'(0));
        @(posedge clk); @(negedge clk);
      end
      d = make_beat(base, b);
      wd_valid = 1'b1; wd_data = d;
      check("st_wd_ready", DW'(wd_ready), DW'(1));
      if (!exp_err) model[int'(row) + b] = d;
      @(posedge clk); @(negedge clk);
    end
    wd_valid = 1'b0;
    check("st_ack", DW'(ack_valid), DW'(1));
    check("st_err", DW'(err), DW'(exp_err));
    check("st_ack_req_ready", DW'(req_ready), DW'(0));
    @(posedge clk); @(negedge clk);
    check("st_ack_drop", DW'(ack_valid), DW'(0));
    check("st_idle_req_ready", DW'(req_ready), DW'(1));
  endtask

  task automatic load_vec(input logic [6:0] row, input bit exp_err, input int stall_beat, input int stall_n);
    logic [DW-1:0] e;
    for (int b = 0; b < 4; b++) exp_q.push_back(exp_err ? '0 : model[int'(row) + b]);
    rsp_ready = 1'b1;
    send_req(1'b0, row);
    check("ld_wait_no_valid", DW'(rsp_valid), DW'(0));
    @(posedge clk); @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      if (b == stall_beat) begin
        rsp_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          check("ld_stall_valid", DW'(rsp_valid), DW'(1));
          check("ld_stall_data", rsp_data, exp_q[0]);
          @(posedge clk); @(negedge clk);
        end
        rsp_ready = 1'b1;
      end
      e = exp_q.pop_front();
      check("ld_valid", DW'(rsp_valid), DW'(1));
      check("ld_data", rsp_data, e);
      check("ld_last", DW'(rsp_last), DW'(b == 3));
      check("ld_err", DW'(err), DW'(exp_err));
      @(posedge clk); @(negedge clk);
    end
    check("ld_valid_drop", DW'(rsp_valid), DW'(0));
    check("ld_idle_req_ready", DW'(req_ready), DW'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_row = '0;
    wd_valid = 1'b0; wd_data = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", DW'(req_ready), DW'(0));
    check("rst_rsp_valid", DW'(rsp_valid), DW'(0));
    check("rst_ack", DW'(ack_valid), DW'(0));
    check("rst_err", DW'(err), DW'(0));
    rst_n = 1'b1;
    #1 check("post_rst_req_ready", DW'(req_ready), DW'(1));
    @(negedge clk);

    // store row 40, lane k of beat b = 100*b+k
    store_vec(7'd40, 0, 1'b0, 1'b0);
    // load right after ack, no backpressure
    load_vec(7'd40, 1'b0, -1, 0);
    // backpressure: 3 stalled cycles on beat 1
    load_vec(7'd40, 1'b0, 1, 3);
    // known contents for rows 116..119
    store_vec(7'd116, 5000, 1'b0, 1'b0);
    // range errors
    load_vec(7'd117, 1'b1, -1, 0);
    store_vec(7'd118, 9000, 1'b1, 1'b0);
    load_vec(7'd116, 1'b0, -1, 0);
    // store with wd_valid toggling every other cycle
    store_vec(7'd50, 20000, 1'b0, 1'b1);
    load_vec(7'd50, 1'b0, 2, 1);

    // reset in the middle of an erroring load (err=1 beforehand)
    rsp_ready = 1'b1;
    send_req(1'b0, 7'd117);
    @(posedge clk); @(negedge clk);
    check("pre_rst_valid", DW'(rsp_valid), DW'(1));
    check("pre_rst_err", DW'(err), DW'(1));
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", DW'(rsp_valid), DW'(0));
    check("midrst_rsp_last", DW'(rsp_last), DW'(0));
    check("midrst_rsp_data", rsp_data, '0);
    check("midrst_err", DW'(err), DW'(0));
    check("midrst_ack", DW'(ack_valid), DW'(0));
    check("midrst_wd_ready", DW'(wd_ready), DW'(0));
    check("midrst_req_ready", DW'(req_ready), DW'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel_req_ready", DW'(req_ready), DW'(1));
    @(negedge clk);
    // memory survives reset
    load_vec(7'd40, 1'b0, -1, 0);

    check("ack_count", DW'(ack_seen), DW'(4));
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
